div_arbiter: RTL
================

# div_arbiter

Round-robin arbiter and sequencer that shares one 8-bit signed non-restoring divider among `NUM_REQ` requesters in the ALU. It accepts one request at a time and drives the divider's `start`/operand interface. It holds the operands stable until the divider's `done` pulse, then returns quotient and remainder to the originating requester. A watchdog recovers from a divider that never completes.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 31: max cycles in WAIT before abort, 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_a` in 8*NUM_REQ: signed dividends, requester i at [8i+7:8i].
- `req_b` in 8*NUM_REQ: signed divisors, same packing.
- `req_ready` out NUM_REQ: one-hot accept pulse (combinational).
- `resp_valid` out NUM_REQ: one-hot, 1-cycle result strobe to the owner.
- `resp_quotient` out 16: signed quotient from the divider.
- `resp_remainder` out 16: signed remainder from the divider.
- `resp_dbz` out 1: divisor was zero, valid with `resp_valid`.
- `resp_timeout` out 1: watchdog abort, valid with `resp_valid`.
- `div_start` out 1: 1-cycle start pulse to the divider.
- `div_a`, `div_b` out 8: registered operands to the divider.
- `div_quotient`, `div_remainder` in 16: divider results.
- `div_done` in 1: divider 1-cycle completion pulse.
- `div_flush` out 1: 1-cycle pulse; parent ORs it into the divider's `reset`.

## Operation
States: IDLE, ISSUE, WAIT, RESP.

- **IDLE:** select the first asserted `req_valid` bit, searching from `(last_grant+1) mod NUM_REQ` upward with wrap.
  - Assert `req_ready[sel]` in the same cycle.
  - Register `div_a`/`div_b` from that requester's slice, and register the id, `dbz = (b==0)`.
  - Set `last_grant <= sel`, go to ISSUE. With no request, stay in IDLE.
- **ISSUE:** `div_start=1` for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- **WAIT:**
  - On `div_done`: capture `div_quotient`/`div_remainder`, `timeout=0`, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, capture zeros, `timeout=1`, go to RESP.
- **RESP:** `resp_valid[id]=1` for one cycle, with `resp_dbz` and `resp_timeout` driven.
  - If `timeout`, also `div_flush=1`.
  - Go to IDLE.
- `div_a`/`div_b` are held constant from ISSUE through RESP inclusive, because the divider re-reads `b` in its DONE state.
- `resp_quotient`/`resp_remainder`/`resp_dbz`/`resp_timeout` hold their last values until the next RESP. They are meaningful only while `resp_valid` is high.
- The arbiter forwards results unmodified; sign and remainder conventions are the divider's.
- Requests that arrive or drop in ISSUE/WAIT/RESP are ignored. A requester must keep `req_valid` high until it sees `req_ready`. Deasserting `req_valid` before the grant withdraws the request.
- Only one transaction is in flight; throughput is at most one per `latency+3` cycles.
- A `div_done` seen outside WAIT is ignored.
- `div_start` is never asserted while `div_done` is high, and never in consecutive cycles.

## Timing
- **Reset values:** state IDLE; `last_grant = NUM_REQ-1`, so requester 0 wins first. All outputs 0: `req_ready`, `resp_valid`, `div_start`, `div_flush`, `div_a`, `div_b`, `resp_*`. Counter 0.
- **Reset mid-transaction:** abandon the transaction, assert no `resp_valid`, return to IDLE next cycle. The divider shares `reset` and is cleared with the arbiter.
- **Latency:** accept at cycle T, `div_start` at T+1. With the team divider, `div_done` arrives at T+13 for b≠0 and at T+4 for b=0. `resp_valid` follows one cycle after `div_done`: T+14 for b≠0, T+5 for b=0.
- **Timeout:** with no `div_done`, `resp_valid` with `resp_timeout=1` occurs at T+TIMEOUT+3, together with `div_flush`.
- **Simultaneous events:**
  - `div_done` in the same cycle the counter reaches TIMEOUT: `div_done` wins.
  - Multiple `req_valid` bits: only the round-robin winner gets `req_ready`.

## Test plan
- **Single request:** reset; `req_valid[0]`, a=100, b=7. Expect `req_ready[0]` in the same cycle, one `div_start` pulse, `resp_valid=4'b0001` with quotient 14, remainder 2, dbz=0, timeout=0, 14 cycles after accept.
- **Divide by zero:** requester 2, a=-50, b=0. Expect `resp_valid[2]`, quotient 0, remainder 0, `resp_dbz=1`, 5 cycles after accept.
- **Round robin:** all four `req_valid` held high continuously. Expect grant order 0,1,2,3,0, each response to the correct requester, `div_a`/`div_b` stable from start to response, no overlapping `div_start`.
- **Watchdog:** divider model never pulses `div_done`, TIMEOUT=5. Expect `resp_timeout=1`, zero results, and `div_flush` 8 cycles after accept. A following request must complete normally.
- **Mid-operation reset:** assert `reset` in WAIT. Expect all outputs 0 next cycle, no `resp_valid`, and requester 0 wins the next grant.
- **Withdrawn request:** `req_valid[1]` pulsed for one cycle while busy in WAIT. Expect no grant to requester 1, and `req_ready` never asserted outside IDLE.

Source files
------------

// File: rtl/div_arbiter.sv
// Round-robin front end for one shared 8-bit signed divider: grants one
// requester at a time, drives the divider, and returns its results with a watchdog.
module div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [15:0]            resp_quotient,
  output logic [15:0]            resp_remainder,
  output logic                   resp_dbz,
  output logic                   resp_timeout,
  output logic                   div_start,
  output logic [7:0]             div_a,
  output logic [7:0]             div_b,
  input  logic [15:0]            div_quotient,
  input  logic [15:0]            div_remainder,
  input  logic                   div_done,
  output logic                   div_flush
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         r_state, w_state_next;
  logic [IDW-1:0] r_last_grant, r_id, w_sel, w_cand;
  logic           w_found, w_accept, w_expire;
  logic [7:0]     r_cnt;
  logic           r_dbz;
  logic [7:0]     r_div_a, r_div_b;
  logic [15:0]    r_quot, r_rem;
  logic           r_resp_dbz, r_resp_timeout;
  logic [7:0]     w_a [NUM_REQ];
  logic [7:0]     w_b [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_a[gi]        = req_a[8*gi +: 8];
      assign w_b[gi]        = req_b[8*gi +: 8];
      assign req_ready[gi]  = w_accept && (w_sel == IDW'(gi));
      assign resp_valid[gi] = (r_state == RESP) && (r_id == IDW'(gi));
    end
  endgenerate

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDW'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_expire = (r_cnt == 8'(TIMEOUT));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    div_start    = 1'b0;
    div_flush    = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = w_found;
        if (w_found) w_state_next = ISSUE;
      end
      ISSUE: begin
        div_start    = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (div_done || w_expire) w_state_next = RESP;
      end
      RESP: begin
        div_flush    = r_resp_timeout;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant   <= IDW'(NUM_REQ - 1);
      r_id           <= '0;
      r_dbz          <= 1'b0;
      r_cnt          <= '0;
      r_div_a        <= '0;
      r_div_b        <= '0;
      r_quot         <= '0;
      r_rem          <= '0;
      r_resp_dbz     <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_div_a      <= w_a[w_sel];
        r_div_b      <= w_b[w_sel];
        r_id         <= w_sel;
        r_dbz        <= (w_b[w_sel] == 8'd0);
        r_last_grant <= w_sel;
      end
      if (r_state == ISSUE) r_cnt <= '0;
      // A done pulse in the expiry cycle still delivers real results.
      if (r_state == WAIT) begin
        if (div_done) begin
          r_quot         <= div_quotient;
          r_rem          <= div_remainder;
          r_resp_dbz     <= r_dbz;
          r_resp_timeout <= 1'b0;
        end else if (w_expire) begin
          r_quot         <= '0;
          r_rem          <= '0;
          r_resp_dbz     <= r_dbz;
          r_resp_timeout <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign div_a          = r_div_a;
  assign div_b          = r_div_b;
  assign resp_quotient  = r_quot;
  assign resp_remainder = r_rem;
  assign resp_dbz       = r_resp_dbz;
  assign resp_timeout   = r_resp_timeout;

endmodule
